// File: rtl/lm32_wb_arbiter.sv
// Two-master Wishbone arbiter (m0 = instruction, m1 = data) with a bus watchdog; one-cycle grant latency,
// zero-latency data/ack paths, ownership held for a whole cyc. `LM32_ARB_ROUND_ROBIN_EN selects round-robin over fixed m1 priority.
module lm32_wb_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_dat_w,
   input  logic [3:0]  m0_sel,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic [2:0]  m0_cti,
   output logic [31:0] m0_dat_r,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_dat_w,
   input  logic [3:0]  m1_sel,
   input  logic        m1_cyc,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic [2:0]  m1_cti,
   output logic [31:0] m1_dat_r,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] s_adr,
   output logic [31:0] s_dat_w,
   output logic [3:0]  s_sel,
   output logic [2:0]  s_cti,
   output logic        s_cyc,
   output logic        s_stb,
   output logic        s_we,
   input  logic [31:0] s_dat_r,
   input  logic        s_ack,
   input  logic        s_err,
   output logic [1:0]  grant
);

   // Encodings chosen so the state register is already the one-hot grant.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_wd_cnt;
   logic        w_cyc;
   logic        w_stb_raw;
   logic        w_stall;
   logic        w_wd_fire;
   logic        w_both_pick0;

`ifdef LM32_ARB_ROUND_ROBIN_EN
   logic r_last_m0;

   // Flag 0 marks m1 as the previous owner, so m0 wins the first contention after reset.
   assign w_both_pick0 = ~r_last_m0;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_last_m0 <= 1'b0;
      end else if (w_next == OWN0) begin
         r_last_m0 <= 1'b1;
      end else if (w_next == OWN1) begin
         r_last_m0 <= 1'b0;
      end
   end
`else
   assign w_both_pick0 = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if ((r_state == IDLE) || (r_state == OWN0 && !m0_cyc) || (r_state == OWN1 && !m1_cyc)) begin
         if (m0_cyc && m1_cyc) begin
            w_next = w_both_pick0 ? OWN0 : OWN1;
         end else if (m0_cyc) begin
            w_next = OWN0;
         end else if (m1_cyc) begin
            w_next = OWN1;
         end else begin
            w_next = IDLE;
         end
      end
   end

   // Stall is judged on the owner's raw strobe so the gated s_stb cannot feed back into the watchdog.
   assign w_stall   = w_cyc & w_stb_raw & ~s_ack & ~s_err;
   assign w_wd_fire = w_stall & (r_wd_cnt == TO_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wd_cnt <= 16'd0;
      end else if (r_state == IDLE || s_ack || s_err || w_wd_fire) begin
         r_wd_cnt <= 16'd0;
      end else if (w_stall) begin
         r_wd_cnt <= r_wd_cnt + 16'd1;
      end
   end

   assign m0_dat_r = s_dat_r;
   assign m1_dat_r = s_dat_r;
   assign grant    = r_state;

   always_comb begin
      w_cyc     = 1'b0;
      w_stb_raw = 1'b0;
      s_adr     = 32'd0;
      s_dat_w   = 32'd0;
      s_sel     = 4'd0;
      s_cti     = 3'd0;
      s_we      = 1'b0;
      m0_ack    = 1'b0;
      m0_err    = 1'b0;
      m1_ack    = 1'b0;
      m1_err    = 1'b0;
      case (r_state)
         OWN0: begin
            w_cyc     = m0_cyc;
            w_stb_raw = m0_stb;
            s_adr     = m0_adr;
            s_dat_w   = m0_dat_w;
            s_sel     = m0_sel;
            s_cti     = m0_cti;
            s_we      = m0_we;
            m0_ack    = s_ack;
            m0_err    = s_err | w_wd_fire;
         end
         OWN1: begin
            w_cyc     = m1_cyc;
            w_stb_raw = m1_stb;
            s_adr     = m1_adr;
            s_dat_w   = m1_dat_w;
            s_sel     = m1_sel;
            s_cti     = m1_cti;
            s_we      = m1_we;
            m1_ack    = s_ack;
            m1_err    = s_err | w_wd_fire;
         end
         default: begin
         end
      endcase
   end

   assign s_cyc = w_cyc;
   assign s_stb = w_stb_raw & ~w_wd_fire;

endmodule

// File: tb/tb_lm32_wb_arbiter.sv
// Directed bench for lm32_wb_arbiter: contention, single read, burst lock, watchdog, ack/err race, async reset.
module tb_lm32_wb_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [31:0] m0_adr, m0_dat_w, m1_adr, m1_dat_w;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [2:0]  m0_cti, m1_cti;
   logic [31:0] m0_dat_r, m1_dat_r;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] s_adr, s_dat_w;
   logic [3:0]  s_sel;
   logic [2:0]  s_cti;
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_dat_r;
   logic        s_ack, s_err;
   logic [1:0]  grant;

   int n_chk = 0;
   int n_err = 0;
   int acks;

`ifdef LM32_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   always #5 sys_clk = ~sys_clk;

   lm32_wb_arbiter #(.TIMEOUT(4)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_cyc(m0_cyc),
      .m0_stb(m0_stb), .m0_we(m0_we), .m0_cti(m0_cti), .m0_dat_r(m0_dat_r),
      .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_cyc(m1_cyc),
      .m1_stb(m1_stb), .m1_we(m1_we), .m1_cti(m1_cti), .m1_dat_r(m1_dat_r),
      .m1_ack(m1_ack), .m1_err(m1_err),
      .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
      .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
      .grant(grant)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic masters_idle();
      m0_adr = 32'd0; m0_dat_w = 32'd0; m0_sel = 4'd0; m0_cyc = 1'b0;
      m0_stb = 1'b0;  m0_we = 1'b0;     m0_cti = 3'd0;
      m1_adr = 32'd0; m1_dat_w = 32'd0; m1_sel = 4'd0; m1_cyc = 1'b0;
      m1_stb = 1'b0;  m1_we = 1'b0;     m1_cti = 3'd0;
   endtask

   initial begin
      sys_rst_n = 1'b0;
      masters_idle();
      s_dat_r = 32'd0; s_ack = 1'b0; s_err = 1'b0;
      #12;
      check("rst_grant", 32'(grant), 0);
      check("rst_s_cyc", 32'(s_cyc), 0);
      check("rst_s_stb", 32'(s_stb), 0);
      check("rst_s_adr", s_adr, 0);
      check("rst_acks",  32'({m0_ack, m1_ack, m0_err, m1_err}), 0);
      @(negedge sys_clk); sys_rst_n = 1'b1;

      // Contention from IDLE straight after reset
      @(negedge sys_clk);
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h200;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h300;
      #1;
      check("con_idle_grant", 32'(grant), 0);
      @(negedge sys_clk); s_ack = 1'b1; #1;
      check("con_first_grant", 32'(grant), RR ? 32'd1 : 32'd2);
      check("con_first_adr", s_adr, RR ? 32'h200 : 32'h300);
      check("con_first_m0_ack", 32'(m0_ack), RR ? 32'd1 : 32'd0);
      check("con_first_m1_ack", 32'(m1_ack), RR ? 32'd0 : 32'd1);
      @(negedge sys_clk); s_ack = 1'b0;
      if (RR) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      else    begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      #1;
      check("con_drop_grant", 32'(grant), RR ? 32'd1 : 32'd2);
      @(negedge sys_clk); s_ack = 1'b1; #1;
      check("con_second_grant", 32'(grant), RR ? 32'd2 : 32'd1);
      check("con_second_adr", s_adr, RR ? 32'h300 : 32'h200);
      check("con_second_m0_ack", 32'(m0_ack), RR ? 32'd0 : 32'd1);
      check("con_second_m1_ack", 32'(m1_ack), RR ? 32'd1 : 32'd0);
      @(negedge sys_clk); s_ack = 1'b0; masters_idle();
      @(negedge sys_clk); #1;
      check("con_end_grant", 32'(grant), 0);

      // Single master read of 0x100, slave acks in the 2nd strobe cycle
      @(negedge sys_clk);
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100; m0_sel = 4'hf; #1;
      check("rd_idle_grant", 32'(grant), 0);
      check("rd_idle_s_cyc", 32'(s_cyc), 0);
      @(negedge sys_clk); #1;
      check("rd_grant", 32'(grant), 1);
      check("rd_s_adr", s_adr, 32'h100);
      check("rd_s_stb", 32'(s_stb), 1);
      check("rd_wait_m0_ack", 32'(m0_ack), 0);
      @(negedge sys_clk); s_ack = 1'b1; s_dat_r = 32'hDEADBEEF; #1;
      check("rd_m0_ack", 32'(m0_ack), 1);
      check("rd_m0_dat_r", m0_dat_r, 32'hDEADBEEF);
      check("rd_m1_ack", 32'(m1_ack), 0);
      @(negedge sys_clk); s_ack = 1'b0; s_dat_r = 32'd0; masters_idle(); #1;
      check("rd_drop_grant", 32'(grant), 1);
      check("rd_drop_s_cyc", 32'(s_cyc), 0);
      @(negedge sys_clk); #1;
      check("rd_end_grant", 32'(grant), 0);

      // m0 4-beat burst, m1 requesting from beat 2
      @(negedge sys_clk);
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_cti = 3'b010; m0_adr = 32'h400;
      acks = 0;
      for (int b = 1; b <= 4; b++) begin
         @(negedge sys_clk);
         m0_adr = 32'h400 + 32'(4 * (b - 1));
         m0_cti = (b == 4) ? 3'b111 : 3'b010;
         s_ack  = 1'b1;
         if (b >= 2) begin m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h500; end
         #1;
         check("bl_grant", 32'(grant), 1);
         check("bl_s_cti", 32'(s_cti), (b == 4) ? 32'd7 : 32'd2);
         check("bl_m1_ack", 32'(m1_ack), 0);
         if (m0_ack) acks++;
      end
      check("bl_acks", 32'(acks), 4);
      @(negedge sys_clk); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_cti = 3'd0; #1;
      check("bl_drop_grant", 32'(grant), 1);
      check("bl_drop_s_cyc", 32'(s_cyc), 0);

      // m1 now owns and the slave never acks: watchdog (TIMEOUT=4) fires in stall cycles 4 and 8
      for (int k = 1; k <= 8; k++) begin
         @(negedge sys_clk); #1;
         check("wd_grant", 32'(grant), 2);
         check("wd_m1_err", 32'(m1_err), (k == 4 || k == 8) ? 32'd1 : 32'd0);
         check("wd_s_stb", 32'(s_stb), (k == 4 || k == 8) ? 32'd0 : 32'd1);
         check("wd_m0_err", 32'(m0_err), 0);
      end
      @(negedge sys_clk); masters_idle();
      @(negedge sys_clk); #1;
      check("wd_end_grant", 32'(grant), 0);

      // Write, with the ack landing in stall cycle TIMEOUT
      @(negedge sys_clk);
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h600;
      m0_dat_w = 32'hCAFEF00D; m0_sel = 4'h3;
      for (int k = 1; k <= 5; k++) begin
         @(negedge sys_clk); s_ack = (k == 4); #1;
         check("race_m0_err", 32'(m0_err), 0);
         if (k == 1) begin
            check("wr_s_we", 32'(s_we), 1);
            check("wr_s_dat_w", s_dat_w, 32'hCAFEF00D);
            check("wr_s_sel", 32'(s_sel), 3);
         end
         if (k == 4) begin
            check("race_m0_ack", 32'(m0_ack), 1);
            check("race_s_stb", 32'(s_stb), 1);
         end
      end
      @(negedge sys_clk); s_ack = 1'b0; masters_idle();
      @(negedge sys_clk);

      // Asynchronous reset while m1 owns the bus
      @(negedge sys_clk); m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h700;
      @(negedge sys_clk); s_ack = 1'b1; #1;
      check("ar_pre_grant", 32'(grant), 2);
      check("ar_pre_m1_ack", 32'(m1_ack), 1);
      #2 sys_rst_n = 1'b0;
      #1;
      check("ar_grant", 32'(grant), 0);
      check("ar_s_cyc", 32'(s_cyc), 0);
      check("ar_s_stb", 32'(s_stb), 0);
      check("ar_m1_ack", 32'(m1_ack), 0);
      @(negedge sys_clk); masters_idle(); s_ack = 1'b0;
      @(negedge sys_clk); sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      #1;
      check("ar_post_grant", 32'(grant), 0);
      check("ar_post_s_cyc", 32'(s_cyc), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
